mux8_deserializer: RTL

//  Receive end of the 8:1 select-mux path: a 1-bit data line plus a 3-bit lane

---
 rtl/mux8_deserializer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mux8_deserializer.sv
// Lane-select deserializer: 1-bit beats with a lane index assemble a LANES-bit frame,
// double-buffered behind a valid/ready output. Optional MUX8_DESER_SEQ_CHECK_EN enforces in-order lanes.
module mux8_deserializer #(
    parameter int LANES = 8,
    parameter int SEL_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LANES-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             dup_err,
    output logic             range_err
`ifdef MUX8_DESER_SEQ_CHECK_EN
    ,
    output logic             seq_err
`endif
);

    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [LANES-1:0] ONE  = {{(LANES-1){1'b0}}, 1'b1};
    localparam logic [LANES-1:0] FULL = '1;

    state_t             state_q, state_d;
    logic [LANES-1:0]   shadow_q, shadow_d;
    logic [LANES-1:0]   mask_q, mask_d;
    logic [LANES-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               dup_err_q, dup_err_d;
    logic               range_err_q, range_err_d;
`ifdef MUX8_DESER_SEQ_CHECK_EN
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);
    logic [SEL_W-1:0]   exp_q, exp_d;
    logic               seq_err_q, seq_err_d;
`endif

    logic               accept, take, slot_free, wr;
    logic [LANES-1:0]   lane, nshadow, nmask;

    assign accept    = in_valid & (state_q == FILL);
    assign take      = out_valid_q & out_ready;
    assign slot_free = ~out_valid_q | out_ready;
    assign lane      = ONE << in_sel;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        mask_d      = mask_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_cnt_d = frame_cnt_q;
        dup_err_d   = 1'b0;
        range_err_d = 1'b0;
        nshadow     = shadow_q;
        nmask       = mask_q;
        wr          = 1'b0;
`ifdef MUX8_DESER_SEQ_CHECK_EN
        exp_d       = exp_q;
        seq_err_d   = 1'b0;
`endif
        if (take) begin
            out_valid_d = 1'b0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (state_q == FILL) begin
            if (accept) begin
                if (32'(in_sel) >= LANES) begin
                    range_err_d = 1'b1;
                end else begin
                    wr = 1'b1;
`ifdef MUX8_DESER_SEQ_CHECK_EN
                    if (in_sel != exp_q) begin
                        // Out-of-order beat restarts the frame; a lane-0 beat seeds the new one.
                        seq_err_d = 1'b1;
                        nshadow   = '0;
                        nmask     = '0;
                        exp_d     = '0;
                        if (in_sel == '0) begin
                            nshadow = in_bit ? ONE : '0;
                            nmask   = ONE;
                            exp_d   = SEL_W'(1);
                        end
                    end else begin
                        nshadow = in_bit ? (shadow_q | lane) : (shadow_q & ~lane);
                        nmask   = mask_q | lane;
                        exp_d   = (exp_q == LAST_LANE) ? '0 : exp_q + SEL_W'(1);
                    end
`else
                    dup_err_d = |(mask_q & lane);
                    nshadow   = in_bit ? (shadow_q | lane) : (shadow_q & ~lane);
                    nmask     = mask_q | lane;
`endif
                end
            end
            if (wr) begin
                if (nmask == FULL && slot_free) begin
                    out_data_d  = nshadow;
                    out_valid_d = 1'b1;
                    shadow_d    = '0;
                    mask_d      = '0;
                end else begin
                    shadow_d = nshadow;
                    mask_d   = nmask;
                    if (nmask == FULL) state_d = HOLD;
                end
            end
        end else if (slot_free) begin
            out_data_d  = shadow_q;
            out_valid_d = 1'b1;
            shadow_d    = '0;
            mask_d      = '0;
            state_d     = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            shadow_q    <= '0;
            mask_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
            dup_err_q   <= 1'b0;
            range_err_q <= 1'b0;
`ifdef MUX8_DESER_SEQ_CHECK_EN
            exp_q       <= '0;
            seq_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            mask_q      <= mask_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
            dup_err_q   <= dup_err_d;
            range_err_q <= range_err_d;
`ifdef MUX8_DESER_SEQ_CHECK_EN
            exp_q       <= exp_d;
            seq_err_q   <= seq_err_d;
`endif
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign dup_err   = dup_err_q;
    assign range_err = range_err_q;
`ifdef MUX8_DESER_SEQ_CHECK_EN
    assign seq_err   = seq_err_q;
`endif

endmodule
